// File: rtl/thr2pry_pkg.sv
// Shared types and elaboration-time helpers for the thermometer-to-priority pipe.
package thr2pry_pkg;

  typedef enum logic {
    DIR_LSB = 1'b0,
    DIR_MSB = 1'b1
  } dir_e;

  // Smallest p with base**p >= number (0 for number <= 1).
  function automatic int clogbase(input int number, input int base);
    int p;
    int v;
    p = 0;
    v = 1;
    if (base >= 2) begin
      while (v < number) begin
        v = v * base;
        p = p + 1;
      end
    end
    return p;
  endfunction

  // Spreads `stages` cuts evenly over `levels` tree levels; the last level always gets one.
  function automatic bit cut_at(input int level, input int stages, input int levels);
    if (levels <= 0) begin
      return 1'b0;
    end else begin
      return (((level + 1) * stages) / levels) > ((level * stages) / levels);
    end
  endfunction

endpackage

// File: rtl/thr2pry_stage.sv
// One SPLIT-ary reduction level of the thermometer tree, with an optional
// valid/ready register slice on its output.
module thr2pry_stage
  import thr2pry_pkg::*;
#(
  parameter int SPLIT = 2,
  parameter int NIN   = 2,
  parameter int SUB   = 1,
  parameter int IW    = 1,
  parameter bit REG   = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [NIN-1:0]           in_any,
  input  logic [NIN-1:0]           in_all,
  input  logic [NIN-1:0]           in_err,
  input  logic [NIN*IW-1:0]        in_idx,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [NIN/SPLIT-1:0]     out_any,
  output logic [NIN/SPLIT-1:0]     out_all,
  output logic [NIN/SPLIT-1:0]     out_err,
  output logic [NIN/SPLIT*IW-1:0]  out_idx
);

  localparam int NOUT = NIN / SPLIT;

  logic [NOUT-1:0]    c_any;
  logic [NOUT-1:0]    c_all;
  logic [NOUT-1:0]    c_err;
  logic [NOUT*IW-1:0] c_idx;

  // Per group: the lowest non-empty child wins; every child above it must be all ones.
  always_comb begin
    logic          found;
    logic          all_ones;
    logic          bad;
    logic          take;
    logic [IW-1:0] idx;
    int            k;
    c_any = '0;
    c_all = '0;
    c_err = '0;
    c_idx = '0;
    for (int g = 0; g < NOUT; g++) begin
      found    = 1'b0;
      all_ones = 1'b1;
      bad      = 1'b0;
      idx      = '0;
      for (int c = 0; c < SPLIT; c++) begin
        k        = g * SPLIT + c;
        take     = ~found & in_any[k];
        bad      = take ? in_err[k] : (bad | (found & ~in_all[k]));
        idx      = take ? (IW'(c * SUB) + in_idx[k*IW +: IW]) : idx;
        found    = found | in_any[k];
        all_ones = all_ones & in_all[k];
      end
      c_any[g]           = found;
      c_all[g]           = all_ones;
      c_err[g]           = bad;
      c_idx[g*IW +: IW]  = idx;
    end
  end

  if (REG) begin : g_reg
    logic               vld_q;
    logic [NOUT-1:0]    any_q;
    logic [NOUT-1:0]    all_q;
    logic [NOUT-1:0]    err_q;
    logic [NOUT*IW-1:0] idx_q;

    assign in_rdy = ~vld_q | out_rdy;

    // Register slice: loads whenever empty or being drained.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        any_q <= '0;
        all_q <= '0;
        err_q <= '0;
        idx_q <= '0;
      end else if (in_rdy) begin
        vld_q <= in_vld;
        any_q <= c_any;
        all_q <= c_all;
        err_q <= c_err;
        idx_q <= c_idx;
      end
    end

    assign out_vld = vld_q;
    assign out_any = any_q;
    assign out_all = all_q;
    assign out_err = err_q;
    assign out_idx = idx_q;
  end else begin : g_pass
    assign in_rdy  = out_rdy;
    assign out_vld = in_vld;
    assign out_any = c_any;
    assign out_all = c_all;
    assign out_err = c_err;
    assign out_idx = c_idx;
  end

endmodule

// File: rtl/thr2pry_pipe.sv
// Thermometer vector to one-hot priority plus binary index, with null/error flags,
// built as a pipelined SPLIT-ary reduction tree with valid/ready on both sides.
module thr2pry_pipe
  import thr2pry_pkg::*;
#(
  parameter int    WIDTH     = 32,
  parameter int    SPLIT     = 2,
  parameter string DIRECTION = "LSB",
  parameter int    STAGES    = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       s_vld,
  output logic                                       s_rdy,
  input  logic [WIDTH-1:0]                           s_thr,
  output logic                                       m_vld,
  input  logic                                       m_rdy,
  output logic [WIDTH-1:0]                           m_pry,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] m_idx,
  output logic                                       m_nul,
  output logic                                       m_err
);

  localparam int   POWER_LOG = clogbase(WIDTH, SPLIT);
  localparam int   POWER     = SPLIT ** POWER_LOG;
  localparam int   IW        = (POWER > 1) ? $clog2(POWER) : 1;
  localparam int   IDXW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam dir_e DIR       = (DIRECTION == "MSB") ? DIR_MSB : DIR_LSB;

  logic [POWER-1:0] padded;
  logic [POWER-1:0] leaf;
  logic             t_vld;
  logic             t_rdy;
  logic             t_any;
  logic             t_err;
  logic [IW-1:0]    t_idx;

  // MSB mode is folded onto the LSB tree by bit reversal of the padded vector.
  always_comb begin
    padded             = '0;
    padded[WIDTH-1:0]  = s_thr;
    for (int i = WIDTH; i < POWER; i++) begin
      padded[i] = (DIR == DIR_LSB) ? s_thr[WIDTH-1] : 1'b0;
    end
    for (int i = 0; i < POWER; i++) begin
      leaf[i] = (DIR == DIR_LSB) ? padded[i] : padded[POWER-1-i];
    end
  end

  if (POWER_LOG == 0) begin : g_flat
    assign t_vld = s_vld;
    assign s_rdy = t_rdy;
    assign t_any = leaf[0];
    assign t_err = 1'b0;
    assign t_idx = '0;
  end else begin : g_tree
    for (genvar l = 0; l < POWER_LOG; l++) begin : lvl
      localparam int NIN  = POWER / (SPLIT ** l);
      localparam int NOUT = NIN / SPLIT;

      logic               i_vld;
      logic               i_rdy;
      logic               o_vld;
      logic               o_rdy;
      logic [NIN-1:0]     i_any;
      logic [NIN-1:0]     i_all;
      logic [NIN-1:0]     i_err;
      logic [NIN*IW-1:0]  i_idx;
      logic [NOUT-1:0]    o_any;
      logic [NOUT-1:0]    o_all;
      logic [NOUT-1:0]    o_err;
      logic [NOUT*IW-1:0] o_idx;

      if (l == 0) begin : g_src
        assign i_vld = s_vld;
        assign s_rdy = i_rdy;
        assign i_any = leaf;
        assign i_all = leaf;
        assign i_err = '0;
        assign i_idx = '0;
      end else begin : g_src
        assign i_vld = lvl[l-1].o_vld;
        assign i_any = lvl[l-1].o_any;
        assign i_all = lvl[l-1].o_all;
        assign i_err = lvl[l-1].o_err;
        assign i_idx = lvl[l-1].o_idx;
      end

      if (l == POWER_LOG - 1) begin : g_snk
        assign o_rdy = t_rdy;
      end else begin : g_snk
        assign o_rdy = lvl[l+1].i_rdy;
      end

      // The cut belonging to the last level is the output register below.
      thr2pry_stage #(
        .SPLIT (SPLIT),
        .NIN   (NIN),
        .SUB   (SPLIT ** l),
        .IW    (IW),
        .REG   (cut_at(l, STAGES, POWER_LOG) && (l != POWER_LOG - 1))
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (i_vld),
        .in_rdy  (i_rdy),
        .in_any  (i_any),
        .in_all  (i_all),
        .in_err  (i_err),
        .in_idx  (i_idx),
        .out_vld (o_vld),
        .out_rdy (o_rdy),
        .out_any (o_any),
        .out_all (o_all),
        .out_err (o_err),
        .out_idx (o_idx)
      );
    end

    assign t_vld = lvl[POWER_LOG-1].o_vld;
    assign t_any = lvl[POWER_LOG-1].o_any[0];
    assign t_err = lvl[POWER_LOG-1].o_err[0];
    assign t_idx = lvl[POWER_LOG-1].o_idx[IW-1:0];
  end

  logic [WIDTH-1:0] f_pry;
  logic [IDXW-1:0]  f_idx;
  logic [IW-1:0]    d_idx;
  logic             f_nul;
  logic             f_err;

  // Undo the reversal on the index and expand it to the one-hot priority.
  always_comb begin
    f_pry = '0;
    f_idx = '0;
    d_idx = (DIR == DIR_LSB) ? t_idx : (IW'(POWER - 1) - t_idx);
    if (t_any) begin
      f_idx = d_idx[IDXW-1:0];
      for (int i = 0; i < WIDTH; i++) begin
        f_pry[i] = (d_idx == IW'(i));
      end
    end else begin
      f_idx = '0;
    end
    f_nul = ~t_any;
    f_err = t_err & t_any;
  end

  if (STAGES > 0) begin : g_oreg
    logic             vld_q;
    logic [WIDTH-1:0] pry_q;
    logic [IDXW-1:0]  idx_q;
    logic             nul_q;
    logic             err_q;

    assign t_rdy = ~vld_q | m_rdy;

    // Output register slice; holds while downstream stalls.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        pry_q <= '0;
        idx_q <= '0;
        nul_q <= 1'b0;
        err_q <= 1'b0;
      end else if (t_rdy) begin
        vld_q <= t_vld;
        pry_q <= f_pry;
        idx_q <= f_idx;
        nul_q <= f_nul;
        err_q <= f_err;
      end
    end

    assign m_vld = vld_q;
    assign m_pry = pry_q;
    assign m_idx = idx_q;
    assign m_nul = nul_q;
    assign m_err = err_q;
  end else begin : g_comb
    assign t_rdy = m_rdy;
    assign m_vld = t_vld;
    assign m_pry = f_pry;
    assign m_idx = f_idx;
    assign m_nul = f_nul;
    assign m_err = f_err;
  end

endmodule

// File: tb/tb_thr2pry_pipe.sv
// Directed and scoreboarded bench for thr2pry_pipe: LSB/MSB 8-bit pipes and a
// 5-bit radix-3 combinational instance.
module tb_thr2pry_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  logic       a_svld = 1'b0, a_srdy, a_mvld, a_mrdy = 1'b1, a_nul, a_err;
  logic [7:0] a_thr = 8'h00, a_pry;
  logic [2:0] a_idx;

  logic       b_svld = 1'b0, b_srdy, b_mvld, b_mrdy = 1'b1, b_nul, b_err;
  logic [7:0] b_thr = 8'h00, b_pry;
  logic [2:0] b_idx;

  logic       c_svld = 1'b0, c_srdy, c_mvld, c_mrdy = 1'b1, c_nul, c_err;
  logic [4:0] c_thr = 5'h00, c_pry;
  logic [2:0] c_idx;

  thr2pry_pipe #(.WIDTH(8), .SPLIT(2), .DIRECTION("LSB"), .STAGES(2)) u_lsb (
    .clk(clk), .rst(rst), .s_vld(a_svld), .s_rdy(a_srdy), .s_thr(a_thr),
    .m_vld(a_mvld), .m_rdy(a_mrdy), .m_pry(a_pry), .m_idx(a_idx), .m_nul(a_nul), .m_err(a_err)
  );

  thr2pry_pipe #(.WIDTH(8), .SPLIT(2), .DIRECTION("MSB"), .STAGES(2)) u_msb (
    .clk(clk), .rst(rst), .s_vld(b_svld), .s_rdy(b_srdy), .s_thr(b_thr),
    .m_vld(b_mvld), .m_rdy(b_mrdy), .m_pry(b_pry), .m_idx(b_idx), .m_nul(b_nul), .m_err(b_err)
  );

  thr2pry_pipe #(.WIDTH(5), .SPLIT(3), .DIRECTION("LSB"), .STAGES(0)) u_pad (
    .clk(clk), .rst(rst), .s_vld(c_svld), .s_rdy(c_srdy), .s_thr(c_thr),
    .m_vld(c_mvld), .m_rdy(c_mrdy), .m_pry(c_pry), .m_idx(c_idx), .m_nul(c_nul), .m_err(c_err)
  );

  // Independent LSB reference: lowest set bit, legal iff thr equals ones from idx upward.
  function automatic void ref_lsb(input logic [7:0] thr, output logic [7:0] pry,
                                  output logic [2:0] idx, output logic nul, output logic err);
    logic [7:0] fill;
    pry = 8'h00; idx = 3'd0; nul = 1'b1; err = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (thr[i]) begin
        pry = 8'h01 << i;
        idx = 3'(i);
        nul = 1'b0;
      end
    end
    fill = 8'hFF << idx;
    err = !nul && (thr != fill);
  endfunction

  // Sends one beat into the LSB (use_msb=0) or MSB pipe and waits for its result.
  task automatic run_beat(input bit use_msb, input logic [7:0] thr, output logic [7:0] pry,
                          output logic [2:0] idx, output logic nul, output logic err,
                          output int lat);
    @(negedge clk);
    if (use_msb) begin b_svld = 1'b1; b_thr = thr; b_mrdy = 1'b1; end
    else begin a_svld = 1'b1; a_thr = thr; a_mrdy = 1'b1; end
    @(negedge clk);
    a_svld = 1'b0;
    b_svld = 1'b0;
    lat = 1;
    while (!(use_msb ? b_mvld : a_mvld) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat >= 20) begin
      bad++;
      $display("FAIL beat_timeout thr=%b: no m_vld within %0d cycles", thr, lat);
    end
    pry = use_msb ? b_pry : a_pry;
    idx = use_msb ? b_idx : a_idx;
    nul = use_msb ? b_nul : a_nul;
    err = use_msb ? b_err : a_err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({a_mvld, a_pry, a_idx, a_nul, a_err} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: got vld=%b pry=%b idx=%0d nul=%b err=%b want all 0",
               a_mvld, a_pry, a_idx, a_nul, a_err);
    end
    total++;
    if (a_srdy !== 1'b1 || b_srdy !== 1'b1) begin
      bad++;
      $display("FAIL reset_srdy: got a=%b b=%b want 1", a_srdy, b_srdy);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (a_srdy !== 1'b1 || a_mvld !== 1'b0 || b_mvld !== 1'b0) begin
      bad++;
      $display("FAIL after_reset: got srdy=%b a_mvld=%b b_mvld=%b want 1 0 0", a_srdy, a_mvld, b_mvld);
    end
  endtask

  task automatic test_lsb();
    logic [7:0] pry; logic [2:0] idx; logic nul, err; int lat;
    run_beat(1'b0, 8'b1111_1000, pry, idx, nul, err, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL lsb_latency: got %0d want 2", lat); end
    total++;
    if ({pry, idx, nul, err} !== {8'b0000_1000, 3'd3, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL lsb_legal: got pry=%b idx=%0d nul=%b err=%b want 00001000 3 0 0", pry, idx, nul, err);
    end
    run_beat(1'b0, 8'b1011_0000, pry, idx, nul, err, lat);
    total++;
    if ({pry, idx, nul, err} !== {8'b0001_0000, 3'd4, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL lsb_err: got pry=%b idx=%0d nul=%b err=%b want 00010000 4 0 1", pry, idx, nul, err);
    end
    run_beat(1'b0, 8'b1111_1111, pry, idx, nul, err, lat);
    total++;
    if ({pry, idx, nul, err} !== {8'b0000_0001, 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL lsb_full: got pry=%b idx=%0d nul=%b err=%b want 00000001 0 0 0", pry, idx, nul, err);
    end
  endtask

  task automatic test_msb();
    logic [7:0] pry; logic [2:0] idx; logic nul, err; int lat;
    run_beat(1'b1, 8'b0000_0111, pry, idx, nul, err, lat);
    total++;
    if ({pry, idx, nul, err} !== {8'b0000_0100, 3'd2, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL msb_legal: got pry=%b idx=%0d nul=%b err=%b want 00000100 2 0 0", pry, idx, nul, err);
    end
    run_beat(1'b1, 8'b0101_0000, pry, idx, nul, err, lat);
    total++;
    if ({pry, idx, nul, err} !== {8'b0100_0000, 3'd6, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL msb_err: got pry=%b idx=%0d nul=%b err=%b want 01000000 6 0 1", pry, idx, nul, err);
    end
  endtask

  task automatic test_null();
    logic [7:0] pry; logic [2:0] idx; logic nul, err; int lat;
    run_beat(1'b0, 8'h00, pry, idx, nul, err, lat);
    total++;
    if ({pry, idx, nul, err} !== {8'h00, 3'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL lsb_null: got pry=%b idx=%0d nul=%b err=%b want 0 0 1 0", pry, idx, nul, err);
    end
    run_beat(1'b1, 8'h00, pry, idx, nul, err, lat);
    total++;
    if ({pry, idx, nul, err} !== {8'h00, 3'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL msb_null: got pry=%b idx=%0d nul=%b err=%b want 0 0 1 0", pry, idx, nul, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] thr_now, e_pry, h_pry;
    logic [2:0] e_idx, h_idx;
    logic       e_nul, e_err, h_nul, h_err;
    bit         pending, stalled;
    int         sent, got, inflight, cyc;
    pending = 1'b0; stalled = 1'b0; sent = 0; got = 0; inflight = 0; thr_now = 8'h00;
    h_pry = 8'h00; h_idx = 3'd0; h_nul = 1'b0; h_err = 1'b0;
    for (cyc = 0; cyc < 400 && got < 16; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        total++;
        if (a_mvld !== 1'b1 || {a_pry, a_idx, a_nul, a_err} !== {h_pry, h_idx, h_nul, h_err}) begin
          bad++;
          $display("FAIL stall_hold: got vld=%b pry=%b idx=%0d want held pry=%b idx=%0d",
                   a_mvld, a_pry, a_idx, h_pry, h_idx);
        end
      end
      if (!pending && sent < 16) begin
        pending = 1'b1;
        thr_now = 8'hFF << $urandom_range(0, 8);
      end
      a_svld = pending;
      a_thr  = thr_now;
      a_mrdy = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (a_srdy !== !(inflight == 2 && !a_mrdy)) begin
        bad++;
        $display("FAIL stream_srdy: got %b want %b (inflight=%0d m_rdy=%b)",
                 a_srdy, !(inflight == 2 && !a_mrdy), inflight, a_mrdy);
      end
      if (a_mvld && a_mrdy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL stream_extra: got beat pry=%b want none", a_pry);
        end else begin
          ref_lsb(exp_q.pop_front(), e_pry, e_idx, e_nul, e_err);
          if ({a_pry, a_idx, a_nul, a_err} !== {e_pry, e_idx, e_nul, e_err}) begin
            bad++;
            $display("FAIL stream_data beat %0d: got pry=%b idx=%0d nul=%b err=%b want %b %0d %b %b",
                     got, a_pry, a_idx, a_nul, a_err, e_pry, e_idx, e_nul, e_err);
          end
        end
        got++;
        inflight--;
      end
      stalled = a_mvld && !a_mrdy;
      h_pry = a_pry; h_idx = a_idx; h_nul = a_nul; h_err = a_err;
      if (a_svld && a_srdy) begin
        exp_q.push_back(thr_now);
        pending = 1'b0;
        sent++;
        inflight++;
      end
    end
    total++;
    if (got != 16) begin
      bad++;
      $display("FAIL stream_count: got %0d beats want 16", got);
    end
    @(negedge clk);
    a_svld = 1'b0;
    a_mrdy = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_padding();
    c_svld = 1'b1; c_mrdy = 1'b1; c_thr = 5'b1_0000;
    #1;
    total++;
    if ({c_mvld, c_srdy, c_pry, c_idx, c_nul, c_err} !== {1'b1, 1'b1, 5'b1_0000, 3'd4, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL pad_top: got vld=%b rdy=%b pry=%b idx=%0d nul=%b err=%b want 1 1 10000 4 0 0",
               c_mvld, c_srdy, c_pry, c_idx, c_nul, c_err);
    end
    c_thr = 5'b1_1100;
    #1;
    total++;
    if ({c_pry, c_idx, c_nul, c_err} !== {5'b0_0100, 3'd2, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL pad_mid: got pry=%b idx=%0d nul=%b err=%b want 00100 2 0 0", c_pry, c_idx, c_nul, c_err);
    end
    c_thr = 5'b0_1100;
    #1;
    total++;
    if ({c_pry, c_idx, c_nul, c_err} !== {5'b0_0100, 3'd2, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL pad_err: got pry=%b idx=%0d nul=%b err=%b want 00100 2 0 1", c_pry, c_idx, c_nul, c_err);
    end
    c_svld = 1'b0; c_mrdy = 1'b0;
    #1;
    total++;
    if (c_mvld !== 1'b0 || c_srdy !== 1'b0) begin
      bad++;
      $display("FAIL pad_handshake: got vld=%b rdy=%b want 0 0", c_mvld, c_srdy);
    end
    c_mrdy = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_mrdy = 1'b0; a_svld = 1'b1; a_thr = 8'b1111_1100;
    @(negedge clk);
    a_thr = 8'b1100_0000;
    @(negedge clk);
    total++;
    if (a_srdy !== 1'b0 || a_mvld !== 1'b1) begin
      bad++;
      $display("FAIL full_pipe: got srdy=%b mvld=%b want 0 1", a_srdy, a_mvld);
    end
    a_svld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({a_mvld, a_pry, a_idx, a_nul, a_err, a_srdy} !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset: got vld=%b pry=%b idx=%0d nul=%b err=%b srdy=%b want 0 0 0 0 0 1",
               a_mvld, a_pry, a_idx, a_nul, a_err, a_srdy);
    end
    rst = 1'b0;
    a_mrdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (a_mvld !== 1'b0) begin
        bad++;
        $display("FAIL stale_beat cycle %0d: got m_vld=%b pry=%b want 0", i, a_mvld, a_pry);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb();
    test_msb();
    test_null();
    test_back_to_back();
    test_padding();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
